master_port: RTL and testbench
==============================

MASTER_PORT -- requirements
Module: master_port

Interface
REQ-001 Parameter ADDR_WIDTH, default 12, address bits carried on the serial bus.
REQ-002 Parameter DATA_WIDTH, default 8, data bits per transfer.
REQ-003 Parameter TIMEOUT, default 255, maximum read-wait cycles; used only when MASTER_PORT_TIMEOUT_EN is defined.
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 dvalid  input  1  parallel request valid.
REQ-007 dready  output  1  port idle and able to accept a request.
REQ-008 dmode  input  1  request type: 0 = read, 1 = write.
REQ-009 daddr  input  ADDR_WIDTH  request address.
REQ-010 dwdata  input  DATA_WIDTH  write data.
REQ-011 drdata  output  DATA_WIDTH  read data, valid while dack = 1.
REQ-012 dack  output  1  one-cycle completion pulse.
REQ-013 derr  output  1  completion with timeout error, valid while dack = 1.
REQ-014 mwdata  output  1  serial address/write-data bit to the slave.
REQ-015 mmode  output  1  bus mode to the slave: 0 = read, 1 = write.
REQ-016 mvalid  output  1  mwdata valid.
REQ-017 mrdata  input  1  serial read-data bit from the slave.
REQ-018 svalid  input  1  mrdata valid.

Function
REQ-019 States: IDLE, ADDR, WDATA, RWAIT, RDATA, DONE; dready = 1 only in IDLE.
REQ-020 Handshake: a request is accepted on the edge where dvalid & dready; daddr, dwdata and dmode are latched; the next state is ADDR.
REQ-021 All serial outputs are registered; for a request accepted at edge T, the first address bit appears on mwdata, with mvalid = 1, in cycle T+1.
REQ-022 ADDR: shift address LSB-first for ADDR_WIDTH cycles; mmode holds the latched mode throughout the transfer.
REQ-023 Write: ADDR -> WDATA; shift data LSB-first for DATA_WIDTH cycles; mvalid stays contiguous for ADDR_WIDTH+DATA_WIDTH cycles; then DONE.
REQ-024 Read: ADDR -> RWAIT with mvalid = 0; RWAIT -> RDATA on the first svalid = 1 cycle, sampling that bit.
REQ-025 Read sampling: mrdata is sampled LSB-first only in cycles with svalid = 1; svalid gaps pause the bit count.
REQ-026 Read completion: after DATA_WIDTH bits have been sampled, go to DONE.
REQ-027 DONE lasts one cycle: dack = 1; drdata holds the assembled word for a read and 0 for a write; then IDLE.
REQ-028 svalid outside RWAIT/RDATA is ignored; dvalid while busy is ignored and not queued.
REQ-029 Back-to-back: a request held on dvalid is accepted on the first IDLE edge after DONE.
REQ-030 Bit counter width is clog2(ADDR_WIDTH+DATA_WIDTH+1); the counter clears on every state change.

Reset
REQ-031 While rst is high: state = IDLE; dready = 1; dack, derr, mvalid, mwdata and mmode = 0; drdata, the shift registers and the counters = 0.
REQ-032 Assertion mid-transfer aborts the transfer immediately with no dack; on release, the first accepted request starts a clean transfer.

Configuration
REQ-033 With MASTER_PORT_TIMEOUT_EN defined, a wait counter runs in RWAIT and RDATA and resets on each svalid = 1 cycle.
REQ-034 When the wait counter reaches TIMEOUT, go to DONE with derr = 1 and drdata = 0.
REQ-035 Without MASTER_PORT_TIMEOUT_EN, the port waits indefinitely, derr is tied to 0, and the port list is unchanged.

Structure
REQ-036 Shared package master_port_pkg holds the state encoding localparams and the default ADDR_WIDTH/DATA_WIDTH constants.
REQ-037 One sub-module, master_shift, holds a parallel-load, LSB-first shift register with serial-in capture, instantiated for both tx and rx paths.

Verification
REQ-038 Write: daddr = 0x5A3, dwdata = 0xC7 accepted at T -> mwdata carries 0x5A3 then 0xC7 LSB-first in T+1..T+20, mmode = 1, dack at T+21.
REQ-039 Read: daddr = 0x010; slave model asserts svalid 3 cycles after mvalid falls and returns 0x3E -> dack with drdata = 0x3E and derr = 0.
REQ-040 svalid gap: 0xA5 is returned with svalid low for 2 cycles after bit 3 -> drdata = 0xA5.
REQ-041 Back-to-back: dvalid held high for a write then a read -> dready low while busy; the read is accepted the edge after dack.
REQ-042 rst pulsed during the 7th address bit -> mvalid drops immediately, no dack, and the next write completes correctly.
REQ-043 MASTER_PORT_TIMEOUT_EN defined, TIMEOUT = 16, read with no svalid -> dack = 1, derr = 1, drdata = 0 exactly 16 cycles after entering RWAIT.

Source files
------------

// File: rtl/master_port_pkg.sv
// Shared definitions for the master_port serial bus master: state encodings and default widths.
package master_port_pkg;

   localparam int MP_ADDR_WIDTH = 12;
   localparam int MP_DATA_WIDTH = 8;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_ADDR  = 3'd1;
   localparam logic [2:0] ST_WDATA = 3'd2;
   localparam logic [2:0] ST_RWAIT = 3'd3;
   localparam logic [2:0] ST_RDATA = 3'd4;
   localparam logic [2:0] ST_DONE  = 3'd5;

   typedef enum logic [2:0] {
      S_IDLE  = ST_IDLE,
      S_ADDR  = ST_ADDR,
      S_WDATA = ST_WDATA,
      S_RWAIT = ST_RWAIT,
      S_RDATA = ST_RDATA,
      S_DONE  = ST_DONE
   } mp_state_e;

endpackage

// File: rtl/master_shift.sv
// Parallel-load shift register, shifting towards bit 0 with serial input captured at the MSB.
module master_shift
   import master_port_pkg::*;
#(
   parameter int W = MP_DATA_WIDTH
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_load,
   input  logic         i_shift,
   input  logic         i_sin,
   input  logic [W-1:0] i_pdata,
   output logic [W-1:0] o_q
);

   logic [W-1:0] r_q;
   logic [W-1:0] w_shifted;

   generate
      if (W == 1) begin : g_narrow
         assign w_shifted = i_sin;
      end else begin : g_wide
         assign w_shifted = {i_sin, r_q[W-1:1]};
      end
   endgenerate

   // load has priority over shift
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q <= '0;
      end else if (i_load) begin
         r_q <= i_pdata;
      end else if (i_shift) begin
         r_q <= w_shifted;
      end else begin
         r_q <= r_q;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/master_port.sv
// Parallel-request to serial-bus master. Optional read-wait timeout enabled by MASTER_PORT_TIMEOUT_EN.
module master_port
   import master_port_pkg::*;
#(
   parameter int ADDR_WIDTH = MP_ADDR_WIDTH,
   parameter int DATA_WIDTH = MP_DATA_WIDTH,
   parameter int TIMEOUT    = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  dvalid,
   output logic                  dready,
   input  logic                  dmode,
   input  logic [ADDR_WIDTH-1:0] daddr,
   input  logic [DATA_WIDTH-1:0] dwdata,
   output logic [DATA_WIDTH-1:0] drdata,
   output logic                  dack,
   output logic                  derr,
   output logic                  mwdata,
   output logic                  mmode,
   output logic                  mvalid,
   input  logic                  mrdata,
   input  logic                  svalid
);

   localparam int FRAME_W = ADDR_WIDTH + DATA_WIDTH;
   localparam int CNT_W   = $clog2(FRAME_W + 1);
   localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);
   // the first read bit is taken in RWAIT, so RDATA counts one fewer
   localparam logic [CNT_W-1:0] RD_LAST   = CNT_W'((DATA_WIDTH > 1) ? (DATA_WIDTH - 2) : 0);

   mp_state_e r_state;
   mp_state_e w_state_next;
   logic [CNT_W-1:0] r_cnt;
   logic r_mmode;
   logic r_mvalid;
   logic r_dack;
   logic r_dready;
   logic w_accept;
   logic w_shift_tx;
   logic w_shift_rx;
   logic w_cnt_step;
   logic w_timeout;
   logic w_wait_expired;
   logic w_rx_clr;
   logic [FRAME_W-1:0]    w_tx_load;
   logic [FRAME_W-1:0]    w_tx_q;
   logic [DATA_WIDTH-1:0] w_rx_q;

   // next-state and per-cycle control decode
   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      w_shift_tx   = 1'b0;
      w_shift_rx   = 1'b0;
      w_cnt_step   = 1'b0;
      w_timeout    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (dvalid) begin
               w_accept     = 1'b1;
               w_state_next = S_ADDR;
            end else begin
               w_state_next = S_IDLE;
            end
         end
         S_ADDR: begin
            w_shift_tx = 1'b1;
            w_cnt_step = 1'b1;
            if (r_cnt == ADDR_LAST) begin
               w_state_next = r_mmode ? S_WDATA : S_RWAIT;
            end else begin
               w_state_next = S_ADDR;
            end
         end
         S_WDATA: begin
            w_shift_tx = 1'b1;
            w_cnt_step = 1'b1;
            if (r_cnt == DATA_LAST) begin
               w_state_next = S_DONE;
            end else begin
               w_state_next = S_WDATA;
            end
         end
         S_RWAIT: begin
            if (svalid) begin
               w_shift_rx   = 1'b1;
               w_state_next = (DATA_WIDTH == 1) ? S_DONE : S_RDATA;
            end else if (w_wait_expired) begin
               w_timeout    = 1'b1;
               w_state_next = S_DONE;
            end else begin
               w_state_next = S_RWAIT;
            end
         end
         S_RDATA: begin
            if (svalid) begin
               w_shift_rx = 1'b1;
               w_cnt_step = 1'b1;
               if (r_cnt == RD_LAST) begin
                  w_state_next = S_DONE;
               end else begin
                  w_state_next = S_RDATA;
               end
            end else if (w_wait_expired) begin
               w_timeout    = 1'b1;
               w_state_next = S_DONE;
            end else begin
               w_state_next = S_RDATA;
            end
         end
         S_DONE: begin
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // state register, bit counter and registered handshake/bus outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_mmode  <= 1'b0;
         r_mvalid <= 1'b0;
         r_dack   <= 1'b0;
         r_dready <= 1'b1;
      end else begin
         r_state <= w_state_next;
         if (w_state_next != r_state) begin
            r_cnt <= '0;
         end else if (w_cnt_step) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end else begin
            r_cnt <= r_cnt;
         end
         if (w_accept) begin
            r_mmode <= dmode;
         end else if (w_state_next == S_IDLE) begin
            r_mmode <= 1'b0;
         end else begin
            r_mmode <= r_mmode;
         end
         r_mvalid <= (w_state_next == S_ADDR) || (w_state_next == S_WDATA);
         r_dack   <= (w_state_next == S_DONE);
         r_dready <= (w_state_next == S_IDLE);
      end
   end

`ifdef MASTER_PORT_TIMEOUT_EN
   localparam int WAIT_W = $clog2(TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

   logic [WAIT_W-1:0] r_wait;
   logic r_derr;
   logic w_waiting;

   assign w_waiting = ((r_state == S_RWAIT) || (r_state == S_RDATA)) &&
                      ((w_state_next == S_RWAIT) || (w_state_next == S_RDATA)) && !svalid;
   // expiry fires on the cycle the counter would reach TIMEOUT
   assign w_wait_expired = (r_wait == WAIT_LAST);

   // read-wait counter, restarted by every valid slave bit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wait <= '0;
         r_derr <= 1'b0;
      end else begin
         if (w_waiting) begin
            r_wait <= r_wait + WAIT_W'(1);
         end else begin
            r_wait <= '0;
         end
         r_derr <= w_timeout;
      end
   end

   assign derr = r_derr;
`else
   // a non-negative TIMEOUT never expires when the wait counter is not built
   assign w_wait_expired = (TIMEOUT < 0);
   assign derr           = 1'b0;
`endif

   assign w_tx_load = {(dmode ? dwdata : {DATA_WIDTH{1'b0}}), daddr};
   assign w_rx_clr  = w_accept || w_timeout || (r_state == S_DONE);

   master_shift #(.W(FRAME_W)) u_tx (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_accept),
      .i_shift (w_shift_tx),
      .i_sin   (1'b0),
      .i_pdata (w_tx_load),
      .o_q     (w_tx_q)
   );

   master_shift #(.W(DATA_WIDTH)) u_rx (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_rx_clr),
      .i_shift (w_shift_rx),
      .i_sin   (mrdata),
      .i_pdata ({DATA_WIDTH{1'b0}}),
      .o_q     (w_rx_q)
   );

   assign dready = r_dready;
   assign dack   = r_dack;
   assign mvalid = r_mvalid;
   assign mmode  = r_mmode;
   assign mwdata = w_tx_q[0];
   assign drdata = w_rx_q;

endmodule

// File: tb/tb_master_port.sv
// Scoreboard bench for master_port: serial frames and completions are checked by independent monitors.
module tb_master_port;

   localparam int AW = 12;
   localparam int DW = 8;

   typedef struct {
      int          start;
      int          len;
      logic        mode;
      logic [31:0] bits;
   } frame_t;

   typedef struct {
      int          cyc;
      logic        err;
      logic [7:0]  data;
   } cmpl_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          dvalid = 1'b0;
   logic          dmode = 1'b0;
   logic [AW-1:0] daddr = '0;
   logic [DW-1:0] dwdata = '0;
   logic          mrdata = 1'b0;
   logic          svalid = 1'b0;
   logic          dready, dack, derr, mwdata, mmode, mvalid;
   logic [DW-1:0] drdata;

   // cyc counts rising edges; the interval following edge n has cyc == n
   int cyc = 0;
   int n_tests = 0;
   int n_fail = 0;

   frame_t fq[$];
   cmpl_t  cq[$];

   master_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(16)) dut (
      .clk    (clk),
      .rst    (rst),
      .dvalid (dvalid),
      .dready (dready),
      .dmode  (dmode),
      .daddr  (daddr),
      .dwdata (dwdata),
      .drdata (drdata),
      .dack   (dack),
      .derr   (derr),
      .mwdata (mwdata),
      .mmode  (mmode),
      .mvalid (mvalid),
      .mrdata (mrdata),
      .svalid (svalid)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   // serial frame monitor: collects contiguous mvalid runs
   initial begin
      int          fb_n;
      int          fb_start;
      logic [31:0] fb_bits;
      logic        fb_mode;
      logic        fb_mode_ok;
      frame_t      ef;
      fb_n = 0; fb_start = 0; fb_bits = '0; fb_mode = 1'b0; fb_mode_ok = 1'b1;
      forever begin
         @(negedge clk);
         if (mvalid === 1'b1) begin
            if (fb_n == 0) begin
               fb_start = cyc; fb_mode = mmode; fb_mode_ok = 1'b1; fb_bits = '0;
            end else if (mmode !== fb_mode) begin
               fb_mode_ok = 1'b0;
            end
            if (fb_n < 32) fb_bits[fb_n] = mwdata;
            fb_n++;
         end else if (fb_n > 0) begin
            if (fq.size() == 0) begin
               check("frame_unexpected", 64'(fq.size()), 64'd1);
            end else begin
               ef = fq.pop_front();
               check("frame_start", 64'(fb_start), 64'(ef.start));
               check("frame_len", 64'(fb_n), 64'(ef.len));
               check("frame_bits", 64'(fb_bits), 64'(ef.bits));
               check("frame_mode", {62'd0, fb_mode_ok, fb_mode}, {62'd0, 1'b1, ef.mode});
            end
            fb_n = 0;
         end
      end
   end

   // completion monitor
   initial begin
      cmpl_t ec;
      forever begin
         @(negedge clk);
         if (dack === 1'b1) begin
            if (cq.size() == 0) begin
               check("dack_unexpected", 64'(cq.size()), 64'd1);
            end else begin
               ec = cq.pop_front();
               check("dack_cycle", 64'(cyc), 64'(ec.cyc));
               check("derr", 64'(derr), 64'(ec.err));
               check("drdata", 64'(drdata), 64'(ec.data));
            end
         end
      end
   end

   // present a request and return the accept edge plus the number of busy (dready low) samples
   task automatic issue(input logic m, input logic [11:0] a, input logic [7:0] d, input logic hold,
                        output int t, output int lowcnt);
      logic   seen;
      int     g;
      frame_t f;
      dvalid = 1'b1; dmode = m; daddr = a; dwdata = d;
      g = 0; lowcnt = 0; seen = 1'b0;
      while (!seen && g < 100) begin
         @(negedge clk);
         seen = (dready === 1'b1);
         if (!seen) lowcnt++;
         @(posedge clk); #1;
         g++;
      end
      check("accept", 64'(seen), 64'd1);
      t = cyc;
      if (!hold) dvalid = 1'b0;
      f.start = t;
      f.len   = m ? (AW + DW) : AW;
      f.mode  = m;
      f.bits  = m ? {12'h000, d, a} : {20'h00000, a};
      fq.push_back(f);
   endtask

   task automatic wait_done(input string name);
      int g;
      g = 0;
      do begin
         @(negedge clk);
         g++;
      end while (dack !== 1'b1 && g < 200);
      check(name, 64'(dack), 64'd1);
      @(posedge clk); #1;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic slave_send(input int start, input logic [7:0] d, input int gap_bit, input int gap_len);
      wait_until(start);
      for (int i = 0; i < DW; i++) begin
         svalid = 1'b1; mrdata = d[i];
         @(posedge clk); #1;
         if (i == gap_bit) begin
            for (int k = 0; k < gap_len; k++) begin
               svalid = 1'b0; mrdata = ~d[i];
               @(posedge clk); #1;
            end
         end
      end
      svalid = 1'b0; mrdata = 1'b0;
   endtask

   task automatic push_cmpl(input int c, input logic e, input logic [7:0] d);
      cmpl_t x;
      x.cyc = c; x.err = e; x.data = d;
      cq.push_back(x);
   endtask

   // read: slave starts 3 cycles after mvalid falls (address ends at t+11)
   task automatic do_read(input logic [11:0] a, input logic [7:0] d, input int gap_bit, input int gap_len);
      int t, lc;
      issue(1'b0, a, 8'h00, 1'b0, t, lc);
      push_cmpl(t + 15 + DW + gap_len, 1'b0, d);
      slave_send(t + 15, d, gap_bit, gap_len);
      wait_done("read_done");
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got cyc %0d, expected completion", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int t, t2, lc, lc2;
      frame_t ef;

      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_state", {50'd0, dready, dack, derr, mvalid, mwdata, mmode, drdata},
            {50'd0, 6'b100000, 8'h00});
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // write with slave noise on svalid, which must be ignored
      issue(1'b1, 12'h5A3, 8'hC7, 1'b0, t, lc);
      push_cmpl(t + 20, 1'b0, 8'h00);
      svalid = 1'b1; mrdata = 1'b1;
      wait_done("write_done");
      svalid = 1'b0; mrdata = 1'b0;

      do_read(12'h010, 8'h3E, -1, 0);
      do_read(12'hFFF, 8'hA5, 3, 2);

      // back-to-back with dvalid held: write then read
      issue(1'b1, 12'h001, 8'hFF, 1'b1, t, lc);
      push_cmpl(t + 20, 1'b0, 8'h00);
      issue(1'b0, 12'h800, 8'h00, 1'b0, t2, lc2);
      check("b2b_accept_edge", 64'(t2), 64'(t + 22));
      check("b2b_busy_samples", 64'(lc2), 64'd21);
      push_cmpl(t2 + 15 + DW, 1'b0, 8'h69);
      slave_send(t2 + 15, 8'h69, -1, 0);
      wait_done("b2b_read_done");

      // reset during the 7th address bit: frame truncated after 7 bits, no completion
      issue(1'b1, 12'h3C5, 8'h96, 1'b0, t, lc);
      ef = fq.pop_back();
      ef.len = 7;
      ef.bits = 32'h0000_0045;
      fq.push_back(ef);
      wait_until(t + 6);
      @(negedge clk); #2;
      rst = 1'b1;
      #1;
      check("abort_mvalid", 64'(mvalid), 64'd0);
      check("abort_dready", 64'(dready), 64'd1);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      issue(1'b1, 12'h0F0, 8'h5C, 1'b0, t, lc);
      push_cmpl(t + 20, 1'b0, 8'h00);
      wait_done("post_reset_write_done");

`ifdef MASTER_PORT_TIMEOUT_EN
      // no slave response: RWAIT spans 16 cycles before DONE
      issue(1'b0, 12'h123, 8'h00, 1'b0, t, lc);
      push_cmpl(t + 28, 1'b1, 8'h00);
      wait_done("timeout_done");
`endif

      repeat (5) @(posedge clk);
      #1;
      check("frames_left", 64'(fq.size()), 64'd0);
      check("cmpl_left", 64'(cq.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
